// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared requester indices, arbiter state encoding and width defaults.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int REQ_IF     = 0;
    localparam int REQ_LD     = 1;
    localparam int REQ_IO     = 2;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_DONE  = 4'b1000
    } arb_state_t;

    // Pointer moves to the requester just after the one-hot winner.
    function automatic logic [1:0] next_ptr(input logic [2:0] win);
        logic [1:0] p;
        p = 2'd0;
        if (win[REQ_IF]) p = 2'd1;
        if (win[REQ_LD]) p = 2'd2;
        if (win[REQ_IO]) p = 2'd0;
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational 3-way round-robin picker, search starts at ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
    import cpu_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] win
);

    always_comb begin
        win = 3'b000;
        case (ptr)
            2'd1: begin
                if      (req[REQ_LD]) win = 3'b010;
                else if (req[REQ_IO]) win = 3'b100;
                else if (req[REQ_IF]) win = 3'b001;
            end
            2'd2: begin
                if      (req[REQ_IO]) win = 3'b100;
                else if (req[REQ_IF]) win = 3'b001;
                else if (req[REQ_LD]) win = 3'b010;
            end
            default: begin
                if      (req[REQ_IF]) win = 3'b001;
                else if (req[REQ_LD]) win = 3'b010;
                else if (req[REQ_IO]) win = 3'b100;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Round-robin share of one memory port between IF, LD and IO.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    output logic [2:0]          gnt,
    output logic [2:0]          done,
    output logic [2:0]          err,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    localparam int                 C_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(TIMEOUT);

    arb_state_t         r_state;
    logic [1:0]         r_ptr;
    logic [C_CNT_W-1:0] r_cnt;
    logic [2:0]         w_win;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;

    rr_pick u_pick (
        .req (req),
        .ptr (r_ptr),
        .win (w_win)
    );

    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_win[i]) begin
                w_we    = we[i];
                w_addr  = addr[i*ADDR_W +: ADDR_W];
                w_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            r_cnt     <= '0;
            gnt       <= 3'b000;
            done      <= 3'b000;
            err       <= 3'b000;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done   <= 3'b000;
            err    <= 3'b000;
            mem_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt       <= w_win;
                        mem_we    <= w_we;
                        mem_addr  <= w_addr;
                        mem_wdata <= w_wdata;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_ISSUE;
                    end
                end
                // ISSUE runs with count 0 and TIMEOUT >= 1, so it can never time out.
                ST_ISSUE, ST_WAIT: begin
                    if (mem_ready) begin
                        done <= gnt;
                        if (!mem_we) rdata <= mem_rdata;
                        r_state <= ST_DONE;
                    end else if (r_cnt == C_TIMEOUT) begin
                        done    <= gnt;
                        err     <= gnt;
                        rdata   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    r_ptr   <= next_ptr(gnt);
                    gnt     <= 3'b000;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    gnt     <= 3'b000;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [23:0] addr;
    logic [23:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [7:0]  rdata;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    int n_total = 0;
    int n_bad   = 0;

    mem_port_arbiter #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_addr [3];

    initial begin
        rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        exp_addr[0] = 8'h10; exp_addr[1] = 8'h21; exp_addr[2] = 8'h32;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // IF read, memory ready on the ISSUE cycle
        req = 3'b001; addr[7:0] = 8'h10; mem_ready = 1'b1; mem_rdata = 8'hA5;
        @(negedge clk);
        check("t1_gnt", 32'(gnt), 32'b001);
        check("t1_mem_en", 32'(mem_en), 1);
        check("t1_mem_addr", 32'(mem_addr), 32'h10);
        check("t1_busy", 32'(busy), 1);
        check("t1_early_done", 32'(done), 0);
        @(negedge clk);
        check("t1_done", 32'(done), 32'b001);
        check("t1_rdata", 32'(rdata), 32'hA5);
        check("t1_mem_en_off", 32'(mem_en), 0);
        check("t1_err", 32'(err), 0);
        req = 3'b000; mem_ready = 1'b0;
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_idle_gnt", 32'(gnt), 0);
        check("t1_idle_done", 32'(done), 0);

        // All three request together from reset: IF, then LD, then IO
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        addr = {8'h32, 8'h21, 8'h10}; mem_ready = 1'b1; mem_rdata = 8'h11; req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_gnt", 32'(gnt), 32'(1 << i));
            check("t2_mem_addr", 32'(mem_addr), 32'(exp_addr[i]));
            @(negedge clk);
            check("t2_done", 32'(done), 32'(1 << i));
            req[i] = 1'b0;
            @(negedge clk);
            check("t2_idle_busy", 32'(busy), 0);
        end
        mem_ready = 1'b0;

        // LD write, ready on the third WAIT cycle
        req = 3'b010; we = 3'b010; addr[15:8] = 8'h20; wdata[15:8] = 8'h3C;
        @(negedge clk);
        check("t3_gnt", 32'(gnt), 32'b010);
        check("t3_mem_we", 32'(mem_we), 1);
        check("t3_mem_wdata", 32'(mem_wdata), 32'h3C);
        check("t3_mem_addr", 32'(mem_addr), 32'h20);
        check("t3_mem_en", 32'(mem_en), 1);
        @(negedge clk);
        check("t3_wait_en", 32'(mem_en), 0);
        check("t3_wait_done", 32'(done), 0);
        @(negedge clk);
        check("t3_wait_gnt", 32'(gnt), 32'b010);
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        check("t3_done", 32'(done), 32'b010);
        check("t3_err", 32'(err), 0);
        check("t3_rdata_kept", 32'(rdata), 32'h11);
        req = 3'b000; we = 3'b000; mem_ready = 1'b0;
        @(negedge clk);
        check("t3_idle_busy", 32'(busy), 0);

        // IO read that times out
        req = 3'b100; addr[23:16] = 8'h40; mem_rdata = 8'hEE;
        @(negedge clk);
        check("t4_gnt", 32'(gnt), 32'b100);
        check("t4_mem_en", 32'(mem_en), 1);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check("t4_wait_done", 32'(done), 0);
        end
        @(negedge clk);
        check("t4_done", 32'(done), 32'b100);
        check("t4_err", 32'(err), 32'b100);
        check("t4_rdata", 32'(rdata), 0);
        req = 3'b000;
        @(negedge clk);
        check("t4_idle_busy", 32'(busy), 0);
        check("t4_idle_gnt", 32'(gnt), 0);
        check("t4_idle_err", 32'(err), 0);

        // LD drops req and changes addr mid-transaction
        req = 3'b010; addr[15:8] = 8'h44;
        @(negedge clk);
        check("t6_mem_addr", 32'(mem_addr), 32'h44);
        @(negedge clk);
        req = 3'b000; addr[15:8] = 8'h99;
        @(negedge clk);
        check("t6_addr_held", 32'(mem_addr), 32'h44);
        check("t6_gnt_held", 32'(gnt), 32'b010);
        mem_ready = 1'b1; mem_rdata = 8'h5A;
        @(negedge clk);
        check("t6_done", 32'(done), 32'b010);
        check("t6_rdata", 32'(rdata), 32'h5A);
        mem_ready = 1'b0;
        @(negedge clk);
        check("t6_done_once", 32'(done), 0);
        check("t6_idle_busy", 32'(busy), 0);
        @(negedge clk);
        check("t6_no_restart", 32'(busy), 0);

        // IF transaction moves the pointer to LD
        req = 3'b001; mem_ready = 1'b1; mem_rdata = 8'h77;
        @(negedge clk);
        check("t7_gnt", 32'(gnt), 32'b001);
        @(negedge clk);
        check("t7_done", 32'(done), 32'b001);
        req = 3'b000; mem_ready = 1'b0;
        @(negedge clk);

        // Reset during WAIT, then IF and LD together
        req = 3'b010;
        @(negedge clk);
        check("t5_gnt", 32'(gnt), 32'b010);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_gnt", 32'(gnt), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_rdata", 32'(rdata), 0);
        check("t5_rst_mem_addr", 32'(mem_addr), 0);
        check("t5_rst_mem", 32'({mem_en, mem_we, mem_wdata, done, err}), 0);
        req = 3'b011;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_gnt_if_first", 32'(gnt), 32'b001);
        mem_ready = 1'b1; mem_rdata = 8'h3E;
        @(negedge clk);
        check("t5_done", 32'(done), 32'b001);
        check("t5_rdata", 32'(rdata), 32'h3E);
        req = 3'b000; mem_ready = 1'b0;
        @(negedge clk);
        check("t5_idle_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
